// File: rtl/divider_scheduler.sv
// Round-robin scheduler that lends one shared divider to two requesters, one whole job at a time.
// Latency: x/inv pairing and quotient return are 1 cycle each. Backpressure: none; blocks move only on the owner's valid.
module divider_scheduler #(
  parameter int REGISTER_SIZE  = 32,
  parameter int NUM_BLOCKS_IN  = 128,
  parameter int NUM_BLOCKS_OUT = 64,
  parameter int GUARD_CYCLES   = 4,
  localparam int AW = (NUM_BLOCKS_IN > 1) ? $clog2(NUM_BLOCKS_IN) : 1
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [1:0]               req_in,
  input  logic [1:0]               x_valid_in,
  input  logic [REGISTER_SIZE-1:0] x_block0_in,
  input  logic [REGISTER_SIZE-1:0] x_block1_in,
  output logic [1:0]               grant_out,
  output logic [AW-1:0]            inv_addr_out,
  input  logic [REGISTER_SIZE-1:0] inv_block_in,
  output logic                     div_valid_out,
  output logic [REGISTER_SIZE-1:0] div_x_block_out,
  output logic [REGISTER_SIZE-1:0] div_inv_block_out,
  output logic                     div_rst_out,
  input  logic                     div_valid_in,
  input  logic [REGISTER_SIZE-1:0] div_block_in,
  output logic                     q_valid_out,
  output logic [REGISTER_SIZE-1:0] q_block_out,
  output logic                     q_tag_out,
  output logic                     q_last_out,
  output logic                     busy_out,
  output logic                     err_out
);

  localparam int ICW = $clog2(NUM_BLOCKS_IN + 1);
  localparam int OCW = $clog2(NUM_BLOCKS_OUT + 1);
  localparam int GCW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  localparam logic [ICW-1:0] IN_MAX   = ICW'(NUM_BLOCKS_IN);
  localparam logic [ICW-1:0] IN_LAST  = ICW'(NUM_BLOCKS_IN - 1);
  localparam logic [OCW-1:0] OUT_MAX  = OCW'(NUM_BLOCKS_OUT);
  localparam logic [OCW-1:0] OUT_LAST = OCW'(NUM_BLOCKS_OUT - 1);
  localparam logic [GCW-1:0] G_LAST   = GCW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    STREAM      = 2'd1,
    WAIT_RESULT = 2'd2,
    GUARD       = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               grant_q, grant_d;
  logic                     owner_q, owner_d;
  logic                     prio_q, prio_d;
  logic [ICW-1:0]           acc_cnt_q, acc_cnt_d;
  logic [OCW-1:0]           out_cnt_q, out_cnt_d;
  logic [GCW-1:0]           guard_cnt_q, guard_cnt_d;
  logic                     pair_vld_q, pair_vld_d;
  logic [REGISTER_SIZE-1:0] x_reg_q, x_reg_d;
  logic                     q_vld_q, q_vld_d;
  logic [REGISTER_SIZE-1:0] q_blk_q, q_blk_d;
  logic                     q_tag_q, q_tag_d;
  logic                     q_last_q, q_last_d;
  logic                     err_q, err_d;
  logic                     grant_idx;
  logic                     x_accept;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    prio_d      = prio_q;
    acc_cnt_d   = acc_cnt_q;
    out_cnt_d   = out_cnt_q;
    guard_cnt_d = guard_cnt_q;
    pair_vld_d  = 1'b0;
    x_reg_d     = x_reg_q;
    q_vld_d     = 1'b0;
    q_blk_d     = q_blk_q;
    q_tag_d     = q_tag_q;
    q_last_d    = 1'b0;
    err_d       = err_q;
    grant_idx   = 1'b0;
    x_accept    = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_in) begin
          // prio_q names the requester that wins a tie; the winner then yields it.
          grant_idx   = (req_in[0] && req_in[1]) ? prio_q : req_in[1];
          owner_d     = grant_idx;
          prio_d      = ~grant_idx;
          grant_d     = grant_idx ? 2'b10 : 2'b01;
          acc_cnt_d   = '0;
          out_cnt_d   = '0;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        x_accept = x_valid_in[owner_q] && (acc_cnt_q < IN_MAX);
        if (x_accept) begin
          pair_vld_d = 1'b1;
          x_reg_d    = owner_q ? x_block1_in : x_block0_in;
          acc_cnt_d  = acc_cnt_q + ICW'(1);
          if (acc_cnt_q == IN_LAST) begin
            grant_d = 2'b00;
            state_d = WAIT_RESULT;
          end
        end
      end
      WAIT_RESULT: begin
        if (div_valid_in && (out_cnt_q < OUT_MAX)) begin
          q_vld_d   = 1'b1;
          q_blk_d   = div_block_in;
          q_tag_d   = owner_q;
          out_cnt_d = out_cnt_q + OCW'(1);
          if (out_cnt_q == OUT_LAST) begin
            q_last_d    = 1'b1;
            guard_cnt_d = '0;
            state_d     = GUARD;
          end
        end
      end
      GUARD: begin
        if (guard_cnt_q == G_LAST) begin
          state_d = IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q + GCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A quotient arriving when no job is waiting for one is a divider protocol fault.
    if (div_valid_in && (state_q != WAIT_RESULT)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      owner_q     <= 1'b0;
      prio_q      <= 1'b0;
      acc_cnt_q   <= '0;
      out_cnt_q   <= '0;
      guard_cnt_q <= '0;
      pair_vld_q  <= 1'b0;
      x_reg_q     <= '0;
      q_vld_q     <= 1'b0;
      q_blk_q     <= '0;
      q_tag_q     <= 1'b0;
      q_last_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      acc_cnt_q   <= acc_cnt_d;
      out_cnt_q   <= out_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      pair_vld_q  <= pair_vld_d;
      x_reg_q     <= x_reg_d;
      q_vld_q     <= q_vld_d;
      q_blk_q     <= q_blk_d;
      q_tag_q     <= q_tag_d;
      q_last_q    <= q_last_d;
      err_q       <= err_d;
    end
  end

  assign grant_out         = grant_q;
  assign inv_addr_out      = acc_cnt_q[AW-1:0];
  assign div_valid_out     = pair_vld_q;
  assign div_x_block_out   = x_reg_q;
  // ROM data is only meaningful the cycle after an accepted address.
  assign div_inv_block_out = pair_vld_q ? inv_block_in : '0;
  assign div_rst_out       = (state_q == GUARD) || !rst_n_in;
  assign q_valid_out       = q_vld_q;
  assign q_block_out       = q_blk_q;
  assign q_tag_out         = q_tag_q;
  assign q_last_out        = q_last_q;
  assign busy_out          = (state_q != IDLE);
  assign err_out           = err_q;

endmodule

// File: doc/divider_scheduler.md
DIVIDER_SCHEDULER -- requirements
Module: divider_scheduler

Interface
REQ-001 Parameter REGISTER_SIZE, 32, block width in bits.
REQ-002 Parameter NUM_BLOCKS_IN, 128, dividend blocks per job.
REQ-003 Parameter NUM_BLOCKS_OUT, 64, quotient blocks per job.
REQ-004 Parameter GUARD_CYCLES, 4, idle cycles between jobs for divider self-clean.
REQ-005 The block SHALL have one clock and asynchronous, active-low reset: clk_in input 1, clock; rst_n_in input 1, async active-low reset.
REQ-006 req_in input 2, per-requester job request, bit i = requester i.
REQ-007 x_valid_in input 2, per-requester dividend-block valid.
REQ-008 x_block0_in / x_block1_in input REGISTER_SIZE each, dividend block from requester 0 / 1, LSB block first.
REQ-009 grant_out output 2, one-hot grant; held for the whole job.
REQ-010 inv_addr_out output clog2(NUM_BLOCKS_IN), mult_inv constant ROM address.
REQ-011 inv_block_in input REGISTER_SIZE, ROM data, valid 1 cycle after address.
REQ-012 div_valid_out / div_x_block_out / div_inv_block_out outputs 1/REGISTER_SIZE/REGISTER_SIZE, paired stream to fixed divider.
REQ-013 div_rst_out output 1, active-high divider reset.
REQ-014 div_valid_in / div_block_in inputs 1/REGISTER_SIZE, quotient stream from divider.
REQ-015 q_valid_out / q_block_out / q_tag_out / q_last_out outputs 1/REGISTER_SIZE/1/1, quotient block to requester q_tag_out; last marks final block.
REQ-016 busy_out output 1, high in any state except IDLE; err_out output 1, sticky protocol error.

Function
REQ-017 States SHALL be IDLE, STREAM, WAIT_RESULT, GUARD.
REQ-018 IDLE: if any req_in bit high, grant one requester, go to STREAM next cycle with grant_out set; else stay.
REQ-019 Arbitration SHALL be round-robin: both requesting -> grant the requester not granted last; after reset requester 0 has priority.
REQ-020 STREAM: a block is accepted only when x_valid_in of the granted requester is high; x_valid_in of non-granted requester is ignored.
REQ-021 Accept counter starts at 0; inv_addr_out SHALL equal the counter in the acceptance cycle; counter increments per accepted block only (gaps allowed).
REQ-022 Accepted x block SHALL be registered; one cycle later div_valid_out=1 with div_x_block_out=registered block and div_inv_block_out=inv_block_in (1-cycle pairing latency).
REQ-023 On the NUM_BLOCKS_IN-th acceptance, grant_out SHALL drop next cycle and state SHALL go to WAIT_RESULT; further x_valid_in ignored.
REQ-024 WAIT_RESULT: each div_valid_in SHALL produce q_valid_out=1, q_block_out=div_block_in, q_tag_out=granted index one cycle later.
REQ-025 Output counter counts div_valid_in; the NUM_BLOCKS_OUT-th block SHALL carry q_last_out=1 and state SHALL go to GUARD.
REQ-026 GUARD: div_rst_out=1 for exactly GUARD_CYCLES cycles, then IDLE; req_in ignored during GUARD.
REQ-027 div_valid_in outside WAIT_RESULT SHALL be dropped (no q_valid_out) and SHALL set err_out.
REQ-028 req_in deasserting mid-STREAM SHALL NOT abort the job; the scheduler waits for remaining blocks.
REQ-029 Counters SHALL never wrap: accept counter saturates at NUM_BLOCKS_IN, output counter at NUM_BLOCKS_OUT.

Reset
REQ-030 While rst_n_in=0, regardless of clock: state IDLE, counters 0, round-robin pointer to requester 0, grant_out=0, div_valid_out=0, q_valid_out=0, q_last_out=0, busy_out=0, err_out=0, data outputs 0, inv_addr_out=0.
REQ-031 div_rst_out SHALL be 1 combinationally while rst_n_in=0.
REQ-032 Reset mid-job SHALL abandon the job; no further q_valid_out for it after release.

Verification
REQ-033 req_in=01, 128 contiguous blocks 0..127, ROM data=addr+1000 -> div pairs (k,k+1000) each one cycle after acceptance; grant_out=01 for 128 acceptances.
REQ-034 Divider returns 64 blocks -> 64 q_valid_out, q_tag_out=0, q_last_out only on 64th; div_rst_out high exactly 4 cycles; busy_out low after.
REQ-035 req_in=11 held for two jobs -> grants 01 then 10; third job grants 01.
REQ-036 Granted requester stalls 3 cycles every 10 blocks, other requester toggles x_valid_in -> exactly 128 div_valid_out, inv_addr_out sequence 0..127 gap-free, no foreign blocks.
REQ-037 div_valid_in pulse in IDLE -> no q_valid_out, err_out=1 sticky until reset.
REQ-038 rst_n_in low at block 50 of STREAM -> all outputs reset immediately, div_rst_out=1; after release, new req_in=10 grants requester 0 first only if requesting, else 10, counters from 0.
